// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial OpA - OpB - BorrowIn with valid/ready handshakes.
// Define SERIAL_SUB_OVERFLOW_EN to build the two's-complement Overflow flag.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    input  logic             BorrowIn,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Diff,
    output logic             BorrowOut,
    output logic             Overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              armed;
    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic [WIDTH-1:0]  res;
    logic              borrow;
    logic [CW-1:0]     cnt;
    logic              last;
    logic              accept;
    logic              d_bit;
    logic              borrow_nxt;

    // The counter runs one past the top bit so the final SHIFT cycle can
    // settle the flags, giving WIDTH+1 edges from accept to OutValid.
    assign last       = (cnt == CW'(WIDTH));
    assign accept     = (state == IDLE) && armed && InValid;
    assign d_bit      = a_sh[0] ^ b_sh[0] ^ borrow;
    assign borrow_nxt = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (last) state_nxt = DONE;
            DONE:    if (OutReady) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            armed  <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
        end else begin
            armed <= 1'b1;
            if (accept) begin
                a_sh   <= OpA;
                b_sh   <= OpB;
                borrow <= BorrowIn;
                cnt    <= '0;
            end else if (state == SHIFT && !last) begin
                a_sh   <= a_sh >> 1;
                b_sh   <= b_sh >> 1;
                borrow <= borrow_nxt;
                res    <= {d_bit, res[WIDTH-1:1]};
                cnt    <= cnt + CW'(1);
            end
        end
    end

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic a_msb;
    logic b_msb;
    logic ovf;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            a_msb <= OpA[WIDTH-1];
            b_msb <= OpB[WIDTH-1];
            ovf   <= 1'b0;
        end else if (state == SHIFT && last) begin
            ovf <= (a_msb ^ b_msb) & (res[WIDTH-1] ^ a_msb);
        end
    end

    assign Overflow = ovf;
`else
    assign Overflow = 1'b0;
`endif

    assign InReady   = armed && (state == IDLE);
    assign OutValid  = (state == DONE);
    assign Diff      = res;
    assign BorrowOut = borrow;

endmodule
